axi_lite_gpio_ctrl: RTL

//  Parametrised AXI4-Lite slave for board GPIO: LED outputs, switch/button inputs, per-input edge interrupts.

---
 rtl/axi_lite_gpio_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_gpio_ctrl.sv
// axi_lite_gpio_ctrl: AXI4-Lite GPIO slave with LED outputs, switch/button inputs and edge interrupts.
// Define GPIO_SYNC_EN to pass switch/button through a 2-flop synchroniser before use.
module axi_lite_gpio_ctrl #(
    parameter int          N_LED    = 8,
    parameter int          N_SW     = 8,
    parameter int          N_BTN    = 5,
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] ID_VALUE = 32'h7E8155AA
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic [N_LED-1:0]  led,
    input  logic [N_SW-1:0]   switch,
    input  logic [N_BTN-1:0]  button,
    output logic              irq
);
    localparam logic [31:0] IN_MASK = (((32'd1 << N_BTN) - 32'd1) << 16) | ((32'd1 << N_SW) - 32'd1);

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    w_state_t          w_state_reg;
    r_state_t          r_state_reg;
    logic              aw_held_reg, w_held_reg, aw_ready_reg, w_ready_reg;
    logic [3:0]        aw_idx_reg;
    logic [31:0]       w_data_reg;
    logic [3:0]        w_strb_reg;
    logic              b_valid_reg;
    logic [1:0]        b_resp_reg;
    logic              ar_ready_reg, r_valid_reg;
    logic [31:0]       r_data_reg;
    logic [1:0]        r_resp_reg;
    logic [N_LED-1:0]  led_reg;
    logic [31:0]       irq_sts_reg, irq_ena_reg, edge_pos_reg, edge_neg_reg;
    logic              irq_reg;
    logic [31:0]       in_prev_reg;
    logic [N_SW-1:0]   sw_s;
    logic [N_BTN-1:0]  btn_s;
    logic [31:0]       in_vec, led_ext, wr_mask, wr_val, rd_val, sts_clr, edge_set;
    logic              aw_hs, w_hs;
    logic              unused_bits;

`ifdef GPIO_SYNC_EN
    logic [N_SW-1:0]  sw_meta_reg, sw_sync_reg;
    logic [N_BTN-1:0] btn_meta_reg, btn_sync_reg;
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            sw_meta_reg  <= '0;
            sw_sync_reg  <= '0;
            btn_meta_reg <= '0;
            btn_sync_reg <= '0;
        end else begin
            sw_meta_reg  <= switch;
            sw_sync_reg  <= sw_meta_reg;
            btn_meta_reg <= button;
            btn_sync_reg <= btn_meta_reg;
        end
    end
    assign sw_s  = sw_sync_reg;
    assign btn_s = btn_sync_reg;
`else
    assign sw_s  = switch;
    assign btn_s = button;
`endif

    assign unused_bits = ^{AWPROT, ARPROT, AWADDR, ARADDR};

    always_comb begin
        in_vec = '0;
        in_vec[N_SW-1:0]   = sw_s;
        in_vec[16 +: N_BTN] = btn_s;
        led_ext = '0;
        led_ext[N_LED-1:0] = led_reg;
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_strb
            assign wr_mask[gi*8 +: 8] = {8{w_strb_reg[gi]}};
        end
    endgenerate

    function automatic logic [31:0] reg_mux(input logic [3:0] idx, input logic [31:0] led_v, in_v,
                                            sts_v, ena_v, pos_v, neg_v);
        case (idx)
            4'd0:    return led_v;
            4'd1:    return in_v;
            4'd2:    return sts_v;
            4'd3:    return ena_v;
            4'd4:    return pos_v;
            4'd5:    return neg_v;
            4'd6:    return ID_VALUE;
            default: return 32'd0;
        endcase
    endfunction

    assign aw_hs    = AWVALID && aw_ready_reg;
    assign w_hs     = WVALID && w_ready_reg;
    assign wr_val   = (reg_mux(aw_idx_reg, led_ext, in_vec, irq_sts_reg, irq_ena_reg, edge_pos_reg, edge_neg_reg)
                       & ~wr_mask) | (w_data_reg & wr_mask);
    assign rd_val   = reg_mux(ARADDR[5:2], led_ext, in_vec, irq_sts_reg, irq_ena_reg, edge_pos_reg, edge_neg_reg);
    assign sts_clr  = (w_state_reg == W_COMMIT && aw_idx_reg == 4'd2) ? (w_data_reg & wr_mask) : 32'd0;
    assign edge_set = ((in_vec & ~in_prev_reg & edge_pos_reg) | (~in_vec & in_prev_reg & edge_neg_reg)) & IN_MASK;

    // Write path and all writable registers; status OR-ing edge_set after the clear makes set win.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_reg  <= W_IDLE;
            aw_held_reg  <= 1'b0;
            w_held_reg   <= 1'b0;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            aw_idx_reg   <= '0;
            w_data_reg   <= '0;
            w_strb_reg   <= '0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= 2'b00;
            led_reg      <= '0;
            irq_sts_reg  <= '0;
            irq_ena_reg  <= '0;
            edge_pos_reg <= '0;
            edge_neg_reg <= '0;
        end else begin
            irq_sts_reg <= (irq_sts_reg & ~sts_clr) | edge_set;
            case (w_state_reg)
                W_IDLE: begin
                    if (!aw_held_reg) begin
                        if (aw_hs) begin
                            aw_held_reg  <= 1'b1;
                            aw_ready_reg <= 1'b0;
                            aw_idx_reg   <= AWADDR[5:2];
                        end else begin
                            aw_ready_reg <= 1'b1;
                        end
                    end
                    if (!w_held_reg) begin
                        if (w_hs) begin
                            w_held_reg  <= 1'b1;
                            w_ready_reg <= 1'b0;
                            w_data_reg  <= WDATA;
                            w_strb_reg  <= WSTRB;
                        end else begin
                            w_ready_reg <= 1'b1;
                        end
                    end
                    if ((aw_held_reg || aw_hs) && (w_held_reg || w_hs))
                        w_state_reg <= W_COMMIT;
                end
                W_COMMIT: begin
                    case (aw_idx_reg)
                        4'd0:    led_reg      <= wr_val[N_LED-1:0];
                        4'd3:    irq_ena_reg  <= wr_val & IN_MASK;
                        4'd4:    edge_pos_reg <= wr_val & IN_MASK;
                        4'd5:    edge_neg_reg <= wr_val & IN_MASK;
                        default: ;
                    endcase
                    b_valid_reg <= 1'b1;
                    b_resp_reg  <= (aw_idx_reg >= 4'd7) ? 2'b11 : 2'b00;
                    w_state_reg <= W_RESP;
                end
                W_RESP: begin
                    if (BREADY) begin
                        b_valid_reg  <= 1'b0;
                        aw_held_reg  <= 1'b0;
                        w_held_reg   <= 1'b0;
                        aw_ready_reg <= 1'b1;
                        w_ready_reg  <= 1'b1;
                        w_state_reg  <= W_IDLE;
                    end
                end
                default: w_state_reg <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_data_reg   <= '0;
            r_resp_reg   <= 2'b00;
        end else begin
            case (r_state_reg)
                R_IDLE: begin
                    if (ARVALID && ar_ready_reg) begin
                        r_data_reg   <= rd_val;
                        r_resp_reg   <= (ARADDR[5:2] >= 4'd7) ? 2'b11 : 2'b00;
                        r_valid_reg  <= 1'b1;
                        ar_ready_reg <= 1'b0;
                        r_state_reg  <= R_DATA;
                    end else begin
                        ar_ready_reg <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_valid_reg  <= 1'b0;
                        ar_ready_reg <= 1'b1;
                        r_state_reg  <= R_IDLE;
                    end
                end
                default: r_state_reg <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            in_prev_reg <= '0;
            irq_reg     <= 1'b0;
        end else begin
            in_prev_reg <= in_vec;
            irq_reg     <= |(irq_sts_reg & irq_ena_reg);
        end
    end

    assign AWREADY = aw_ready_reg;
    assign WREADY  = w_ready_reg;
    assign BVALID  = b_valid_reg;
    assign BRESP   = b_resp_reg;
    assign ARREADY = ar_ready_reg;
    assign RVALID  = r_valid_reg;
    assign RDATA   = r_data_reg;
    assign RRESP   = r_resp_reg;
    assign led     = led_reg;
    assign irq     = irq_reg;
endmodule
